imem_read_responder: RTL

- Instruction-memory responder that serves the fetch stage's read port.
- Accepts a byte address plus enable each cycle and returns the addressed 32-bit word after a fixed, parameterised pipeline latency, with alignment and range status.
- Includes a byte-strobed load port so the bench or boot loader can write program images.
- With LATENCY=1, read data lines up with the fetch stage's registered program counter.

---
 rtl/imem_read_responder_if.sv | 28 ++
 rtl/imem_read_responder.sv | 96 +++++++++
 2 files changed

// File: rtl/imem_read_responder_if.sv
// Fetch-side read port plus program-load port of the instruction memory.
interface imem_read_responder_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   rd_enable;
    logic [WIDTH-1:0]       rd_address;
    logic [WIDTH-1:0]       rd_data;
    logic                   rd_valid;
    logic                   rd_misaligned;
    logic                   rd_out_of_range;
    logic                   ld_enable;
    logic [WIDTH-1:0]       ld_address;
    logic [WIDTH-1:0]       ld_data;
    logic [WIDTH/8-1:0]     ld_strobe;
    logic                   ld_error;

    // Fetch stage / boot loader side.
    modport master (
        output rd_enable, rd_address, ld_enable, ld_address, ld_data, ld_strobe,
        input  rd_data, rd_valid, rd_misaligned, rd_out_of_range, ld_error
    );

    // Memory side.
    modport slave (
        input  rd_enable, rd_address, ld_enable, ld_address, ld_data, ld_strobe,
        output rd_data, rd_valid, rd_misaligned, rd_out_of_range, ld_error
    );
endinterface

// File: rtl/imem_read_responder.sv
// Instruction memory with a fixed-latency pipelined read port and a byte-strobed load port.
module imem_read_responder #(
    parameter int unsigned     WIDTH    = 32,
    parameter int unsigned     DEPTH    = 1024,
    parameter int unsigned     LATENCY  = 1,
    parameter logic [WIDTH-1:0] NOP_WORD = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_read_responder_if.slave bus
);
    localparam int unsigned      AW         = $clog2(DEPTH);
    localparam int unsigned      NBYTES     = WIDTH / 8;
    localparam logic [WIDTH-1:0] BYTE_LIMIT = WIDTH'(DEPTH * 4);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("imem_read_responder: LATENCY must be in 1..4");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic             valid_q [LATENCY];
    logic             mis_q   [LATENCY];
    logic             oor_q   [LATENCY];
    logic [WIDTH-1:0] word_q  [LATENCY];
    logic             ld_error_q;

    logic [AW-1:0]    rd_index_c;
    logic [AW-1:0]    ld_index_c;
    logic             rd_mis_c;
    logic             rd_oor_c;
    logic             ld_in_range_c;

    // Request decode: word index and fault classification.
    always_comb begin
        rd_index_c    = bus.rd_address[AW+1:2];
        ld_index_c    = bus.ld_address[AW+1:2];
        rd_mis_c      = (bus.rd_address[1:0] != 2'b00);
        rd_oor_c      = (bus.rd_address >= BYTE_LIMIT);
        ld_in_range_c = (bus.ld_address < BYTE_LIMIT);
    end

    // Byte-strobed program load; storage is never reset.
    always_ff @(posedge clk) begin
        if (bus.ld_enable && ld_in_range_c) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (bus.ld_strobe[i]) begin
                    mem[ld_index_c][8*i +: 8] <= bus.ld_data[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline; the array read sees pre-load contents on a same-edge collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                mis_q[i]   <= 1'b0;
                oor_q[i]   <= 1'b0;
                word_q[i]  <= NOP_WORD;
            end
        end else begin
            valid_q[0] <= bus.rd_enable;
            mis_q[0]   <= bus.rd_enable && rd_mis_c;
            oor_q[0]   <= bus.rd_enable && rd_oor_c;
            if (bus.rd_enable) begin
                word_q[0] <= (rd_mis_c || rd_oor_c) ? NOP_WORD : mem[rd_index_c];
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                mis_q[i]   <= mis_q[i-1];
                oor_q[i]   <= oor_q[i-1];
                if (valid_q[i-1]) begin
                    word_q[i] <= word_q[i-1];
                end
            end
        end
    end

    // One-cycle error pulse for a load outside the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_error_q <= 1'b0;
        end else begin
            ld_error_q <= bus.ld_enable && !ld_in_range_c;
        end
    end

    assign bus.rd_data         = word_q[LATENCY-1];
    assign bus.rd_valid        = valid_q[LATENCY-1];
    assign bus.rd_misaligned   = mis_q[LATENCY-1];
    assign bus.rd_out_of_range = oor_q[LATENCY-1];
    assign bus.ld_error        = ld_error_q;

endmodule
